decim_frame_buffer: RTL and testbench

- Downstream stage of the low-pass FIR filter.
- Consumes the filtered 8-bit audio stream on its data-ready strobe and decimates it by DECIM_FACTOR. The FIR acts as the anti-alias filter.
- Stores decimated samples in a dual-pointer ring buffer.
- Streams complete frames of FRAME_LEN samples, oldest first, over a valid/ready/last handshake to the pitch-analysis (FFT) stage.

---
 rtl/decim_frame_buffer.sv | 132 +++++++++++++
 tb/tb_decim_frame_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decim_frame_buffer.sv
// Decimating frame buffer: keeps 1 of DECIM_FACTOR FIR samples in a 2*FRAME_LEN ring and
// streams FRAME_LEN-sample frames oldest first. Define FRAME_OVERLAP_EN for 50% frame overlap.
module decim_frame_buffer #(
    parameter int DECIM_FACTOR = 4,
    parameter int FRAME_LEN    = 1024,
    parameter int SAMPLE_W     = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [SAMPLE_W-1:0] audio_in,
    input  logic                audio_valid_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid_out,
    input  logic                sample_ready_in,
    output logic                sample_last_out,
    output logic [15:0]         frame_count_out,
    output logic                overflow_out
);
    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int CW    = $clog2(FRAME_LEN);
    localparam int PH_W  = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
`ifdef FRAME_OVERLAP_EN
    localparam int HOP = FRAME_LEN / 2;
`else
    localparam int HOP = FRAME_LEN;
`endif

    typedef enum logic {FILL, STREAM} state_t;

    logic signed [SAMPLE_W-1:0] ram [DEPTH];

    logic [PH_W-1:0] phase;
    logic [PW-1:0]   wp;
    logic [PW-1:0]   fs;
    logic [PW-1:0]   rp;
    logic [PW-1:0]   rp_nxt;
    logic [PW-1:0]   occ;
    logic            keep_p0;
    logic            wr_en_p0;
    logic            ovf;

    state_t                     state;
    logic [CW-1:0]              idx;
    logic signed [SAMPLE_W-1:0] sample_p1;
    logic                       vld_p1;
    logic                       last_p1;
    logic [15:0]                frame_cnt;

    // Extra pointer MSB lets occ reach DEPTH, so full and empty stay distinct.
    assign occ      = wp - fs;
    assign rp_nxt   = rp + PW'(1);
    assign keep_p0  = audio_valid_in && (phase == '0);
    assign wr_en_p0 = keep_p0 && (occ < PW'(DEPTH));

    // Stage p0: decimation phase, write pointer and sticky drop flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase <= '0;
            wp    <= '0;
            ovf   <= 1'b0;
        end else begin
            if (audio_valid_in) begin
                phase <= (phase == PH_W'(DECIM_FACTOR - 1)) ? '0 : phase + PH_W'(1);
            end
            if (wr_en_p0) begin
                wp <= wp + PW'(1);
            end else if (keep_p0) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en_p0) begin
            ram[wp[AW-1:0]] <= audio_in;
        end
    end

    // Stage p1: registered RAM read doubles as the output holding register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= FILL;
            fs        <= '0;
            rp        <= '0;
            idx       <= '0;
            sample_p1 <= '0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (occ >= PW'(FRAME_LEN)) begin
                        rp    <= fs;
                        idx   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (!vld_p1) begin
                        sample_p1 <= ram[rp[AW-1:0]];
                        vld_p1    <= 1'b1;
                        last_p1   <= 1'b0;
                    end else if (sample_ready_in) begin
                        if (last_p1) begin
                            vld_p1    <= 1'b0;
                            last_p1   <= 1'b0;
                            fs        <= fs + PW'(HOP);
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= FILL;
                        end else begin
                            // Fetch the successor in the handshake cycle to sustain one sample per clock.
                            rp        <= rp_nxt;
                            idx       <= idx + CW'(1);
                            sample_p1 <= ram[rp_nxt[AW-1:0]];
                            last_p1   <= (idx == CW'(FRAME_LEN - 2));
                        end
                    end
                end
            endcase
        end
    end

    assign sample_out       = sample_p1;
    assign sample_valid_out = vld_p1;
    assign sample_last_out  = last_p1;
    assign frame_count_out  = frame_cnt;
    assign overflow_out     = ovf;

endmodule

// File: tb/tb_decim_frame_buffer.sv
// Bench for decim_frame_buffer: two instances (decimate by 4 and by 1) checked every cycle
// against a sample-list reference model, plus directed scenarios with literal expectations.
module tb_decim_frame_buffer;
    localparam int F  = 16;
    localparam int SW = 8;
    localparam int MW = 4096;
`ifdef FRAME_OVERLAP_EN
    localparam int HOP = F / 2;
`else
    localparam int HOP = F;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [SW-1:0] ain_a, ain_b;
    logic          stb_a, stb_b, rdy_a, rdy_b;
    logic [SW-1:0] smp_a, smp_b;
    logic          vld_a, vld_b, last_a, last_b, ovf_a, ovf_b;
    logic [15:0]   fc_a, fc_b;

    decim_frame_buffer #(.DECIM_FACTOR(4), .FRAME_LEN(F), .SAMPLE_W(SW)) dut_a (
        .clk_in(clk), .rst_in(rst), .audio_in(ain_a), .audio_valid_in(stb_a),
        .sample_out(smp_a), .sample_valid_out(vld_a), .sample_ready_in(rdy_a),
        .sample_last_out(last_a), .frame_count_out(fc_a), .overflow_out(ovf_a)
    );

    decim_frame_buffer #(.DECIM_FACTOR(1), .FRAME_LEN(F), .SAMPLE_W(SW)) dut_b (
        .clk_in(clk), .rst_in(rst), .audio_in(ain_b), .audio_valid_in(stb_b),
        .sample_out(smp_b), .sample_valid_out(vld_b), .sample_ready_in(rdy_b),
        .sample_last_out(last_b), .frame_count_out(fc_b), .overflow_out(ovf_b)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: list of stored samples; frame j covers stored[j*HOP .. j*HOP+F-1].
    int            dec [2] = '{4, 1};
    int            phase [2];
    int            wcnt [2];
    int            k [2];
    int            pos [2];
    int            fcnt [2];
    int            idle [2];
    bit            ovf_m [2];
    bit            exp_zero [2] = '{1'b1, 1'b1};
    logic [SW-1:0] mem [2][MW];
    int            got_a[$];
    int            got_b[$];
    int            lastv_a = -1;
    int            lastv_b = -1;

    task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s unit%0d: got %0d expected %0d at %0t", name, u, act, exp, $time);
        end
    endtask

    task automatic model_step(input int u, input logic r, input logic v, input logic [SW-1:0] s,
                              input logic l, input logic [15:0] fc, input logic ov,
                              input logic st, input logic [SW-1:0] din, input logic rd);
        bit avail;
        if (exp_zero[u]) begin
            chk("rst_valid", u, v, 0);
            chk("rst_sample", u, s, 0);
            chk("rst_last", u, l, 0);
            chk("rst_fcount", u, fc, 0);
            chk("rst_overflow", u, ov, 0);
        end
        chk("frame_count", u, fc, fcnt[u]);
        chk("overflow", u, ov, ovf_m[u]);
        avail = (wcnt[u] >= k[u] * HOP + F);
        if (v === 1'b1) begin
            idle[u] = 0;
            chk("valid_allowed", u, avail, 1);
            if (avail) begin
                chk("sample", u, s, mem[u][(k[u] * HOP + pos[u]) % MW]);
                chk("last", u, l, (pos[u] == F - 1));
            end
        end else if (avail && !exp_zero[u]) begin
            idle[u]++;
            if (idle[u] > 3) begin
                chk("valid_latency", u, idle[u], 3);
                idle[u] = 0;
            end
        end

        if (r === 1'b1) begin
            exp_zero[u] = 1'b1;
            phase[u] = 0; wcnt[u] = 0; k[u] = 0; pos[u] = 0;
            fcnt[u] = 0; ovf_m[u] = 1'b0; idle[u] = 0;
        end else begin
            exp_zero[u] = 1'b0;
            if (st === 1'b1) begin
                if (phase[u] == 0) begin
                    if (wcnt[u] - k[u] * HOP < 2 * F) begin
                        mem[u][wcnt[u] % MW] = din;
                        wcnt[u]++;
                    end else begin
                        ovf_m[u] = 1'b1;
                    end
                end
                phase[u] = (phase[u] + 1) % dec[u];
            end
            if (v === 1'b1 && rd === 1'b1 && avail) begin
                if (u == 0) begin
                    got_a.push_back(int'(s));
                    if (l) lastv_a = int'(s);
                end else begin
                    got_b.push_back(int'(s));
                    if (l) lastv_b = int'(s);
                end
                pos[u]++;
                if (pos[u] == F) begin
                    pos[u] = 0;
                    k[u]++;
                    fcnt[u] = (fcnt[u] + 1) % 65536;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, rst, vld_a, smp_a, last_a, fc_a, ovf_a, stb_a, ain_a, rdy_a);
        model_step(1, rst, vld_b, smp_b, last_b, fc_b, ovf_b, stb_b, ain_b, rdy_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rmode(input int m, input int c);
        case (m)
            0:       return 1'b1;
            1:       return (c % 3 == 0);
            2:       return 1'b0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        stb_a = 1'b0; stb_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got_a.delete(); got_b.delete();
        lastv_a = -1; lastv_b = -1;
    endtask

    task automatic run_a(input int n, input int m, input int tail, input int base);
        for (int c = 0; c < n + tail; c++) begin
            stb_a = (c < n);
            ain_a = SW'(base + c);
            rdy_a = rmode(m, c);
            tick();
        end
        stb_a = 1'b0;
    endtask

    task automatic run_b(input int n, input int m, input int tail, input int base);
        for (int c = 0; c < n + tail; c++) begin
            stb_b = (c < n);
            ain_b = SW'(base + c);
            rdy_b = rmode(m, c);
            tick();
        end
        stb_b = 1'b0;
    endtask

    initial begin
        int nf;
        rst = 1'b1;
        ain_a = '0; ain_b = '0;
        stb_a = 1'b0; stb_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;

        // Decimation and ordering, ready held high
        do_reset();
        run_a(64, 0, 40, 0);
        chk("t1_count", 0, got_a.size(), 16);
        for (int i = 0; i < got_a.size(); i++) chk("t1_order", 0, got_a[i], 4 * i);
        chk("t1_last_value", 0, lastv_a, 60);
        chk("t1_frames", 0, fc_a, 1);
        chk("t1_valid_drop", 0, vld_a, 0);

        // Backpressure 1,0,0 pattern
        do_reset();
        run_a(64, 1, 80, 0);
        chk("t2_count", 0, got_a.size(), 16);
        for (int i = 0; i < got_a.size(); i++) chk("t2_order", 0, got_a[i], 4 * i);
        chk("t2_frames", 0, fc_a, 1);

        // Overflow with the consumer stalled
        do_reset();
        run_a(128, 2, 0, 0);
        chk("t3_no_overflow_yet", 0, ovf_a, 0);
        run_a(32, 2, 0, 128);
        chk("t3_overflow", 0, ovf_a, 1);
        chk("t3_held_valid", 0, vld_a, 1);
        chk("t3_held_sample", 0, smp_a, 0);
        run_a(0, 0, 60, 0);
        chk("t3_count", 0, got_a.size(), 32);
        for (int i = 0; i < got_a.size(); i++) chk("t3_order", 0, got_a[i], 4 * i);
        chk("t3_frames", 0, fc_a, 2);
        chk("t3_overflow_sticky", 0, ovf_a, 1);

        // Reset after the 5th handshake of a frame
        do_reset();
        run_a(80, 2, 2, 0);
        run_a(0, 0, 5, 0);
        chk("t5_handshakes", 0, got_a.size(), 5);
        rdy_a = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5_rst_valid", 0, vld_a, 0);
        chk("t5_rst_sample", 0, smp_a, 0);
        chk("t5_rst_last", 0, last_a, 0);
        chk("t5_rst_fcount", 0, fc_a, 0);
        rst = 1'b0;
        got_a.delete();
        lastv_a = -1;
        run_a(64, 0, 40, 100);
        chk("t5_count", 0, got_a.size(), 16);
        if (got_a.size() > 0) chk("t5_first", 0, got_a[0], 100);
        chk("t5_last_value", 0, lastv_a, 160);

        // No decimation, continuous input with ready high (overlap when enabled)
        do_reset();
        run_b(32, 0, 80, 0);
`ifdef FRAME_OVERLAP_EN
        nf = 3;
`else
        nf = 2;
`endif
        chk("t46_count", 1, got_b.size(), nf * F);
        for (int i = 0; i < got_b.size(); i++) chk("t46_order", 1, got_b[i], (i / F) * HOP + (i % F));
        chk("t46_frames", 1, fc_b, nf);
        chk("t46_no_overflow", 1, ovf_b, 0);

        // Randomized traffic on both instances, one mid-run reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst   = (c == 1700);
            stb_a = 1'($urandom_range(0, 1));
            ain_a = SW'($urandom);
            stb_b = ($urandom_range(0, 9) < 7);
            ain_b = SW'($urandom);
            rdy_a = ($urandom_range(0, 3) != 0);
            rdy_b = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0;
        stb_a = 1'b0; stb_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        for (int c = 0; c < 120; c++) tick();
        chk("rand_drain_valid_a", 0, vld_a, 0);
        chk("rand_drain_valid_b", 1, vld_b, 0);
        chk("rand_progress_a", 0, (fc_a != 16'd0), 1);
        chk("rand_progress_b", 1, (fc_b != 16'd0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
